alu_issue_ctrl: RTL and testbench

- Front-end sequencer that sits directly upstream of the 8-bit ALU FSM.
- Accepts operation requests over a valid/ready handshake, registers the operands, and pulses BEGIN.
- Waits for END, then captures the ALU's 16-bit OUT into a result register and presents it downstream over valid/ready.
- A watchdog flags ALU runs that never assert END.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_issue_ctrl_if.sv | 46 ++++
 rtl/alu_watchdog.sv | 31 +++
 rtl/alu_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue path.
// Holds the sequencer state encoding, opcode constants and the operand register layout.
package alu_pkg;

  localparam int ALU_W = 8;
  localparam int OUT_W = 16;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_END,
    HOLD
  } state_t;

  typedef struct packed {
    logic [ALU_W-1:0] a_div;
    logic [ALU_W-1:0] x;
    logic [ALU_W-1:0] y;
    logic [2:0]       op;
  } opnd_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-side and result signals of the issue controller in one bundle.
// slave is the controller's view; master is the environment (requester, ALU, consumer).
interface alu_issue_ctrl_if;
  import alu_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [ALU_W-1:0] req_x;
  logic [ALU_W-1:0] req_y;
  logic [ALU_W-1:0] req_a_div;
  logic [2:0]       req_op;

  logic [ALU_W-1:0] alu_x;
  logic [ALU_W-1:0] alu_y;
  logic [ALU_W-1:0] alu_a_div;
  logic [2:0]       alu_op;
  logic             alu_begin;
  logic             alu_end;
  logic [OUT_W-1:0] alu_out;

  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;
  logic [2:0]       res_op;
  logic             res_timeout;
  logic             busy;

  modport slave (
    input  req_valid, req_x, req_y, req_a_div, req_op,
    output req_ready,
    output alu_x, alu_y, alu_a_div, alu_op, alu_begin,
    input  alu_end, alu_out,
    output res_valid, res_data, res_op, res_timeout, busy,
    input  res_ready
  );

  modport master (
    output req_valid, req_x, req_y, req_a_div, req_op,
    input  req_ready,
    input  alu_x, alu_y, alu_a_div, alu_op, alu_begin,
    output alu_end, alu_out,
    input  res_valid, res_data, res_op, res_timeout, busy,
    output res_ready
  );

endinterface

// File: rtl/alu_watchdog.sv
// Loadable up-counter with clear; o_tc flags the LIMIT-th enabled cycle since clear.
// Saturates at all-ones so a forgotten enable cannot wrap back to zero.
module alu_watchdog #(
  parameter int LIMIT = 64,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt counts completed enabled cycles, so the LIMIT-th one sees LIMIT-1
  assign o_tc = i_en && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencer in front of the multi-cycle ALU: accept, pulse BEGIN, wait END (with watchdog), hold result.
// Latency accept->res_valid = BEGIN_CYCLES + N + 1; req_ready is the only combinational output.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int BEGIN_CYCLES = 1,
  parameter int TIMEOUT      = 64
) (
  input  logic           clk,
  input  logic           reset,
  alu_issue_ctrl_if.slave bus
);

  state_t           r_state;
  opnd_t            r_opnd;
  logic [2:0]       r_beg_cnt;
  logic             r_alu_begin;
  logic             r_res_valid;
  logic             r_res_timeout;
  logic [OUT_W-1:0] r_res_data;
  logic [2:0]       r_res_op;
  logic             r_busy;

  logic             w_req_ready;
  logic             w_accept;
  logic             w_launch_done;
  logic             w_wait;
  logic             w_wd_tc;

  assign w_req_ready   = (r_state == IDLE) || ((r_state == HOLD) && bus.res_ready);
  assign w_accept      = bus.req_valid && w_req_ready;
  assign w_launch_done = (r_state == LAUNCH) && (r_beg_cnt == 3'(BEGIN_CYCLES - 1));
  assign w_wait        = (r_state == WAIT_END);

  alu_watchdog #(
    .LIMIT (TIMEOUT),
    .W     (8)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_launch_done),
    .i_en       (w_wait),
    .i_load     (1'b0),
    .i_load_val (8'd0),
    .o_tc       (w_wd_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_opnd        <= '0;
      r_beg_cnt     <= '0;
      r_alu_begin   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_timeout <= 1'b0;
      r_res_data    <= '0;
      r_res_op      <= '0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        LAUNCH: begin
          // END is deliberately not looked at here: a level left over from the last run must not complete this one
          if (w_launch_done) begin
            r_alu_begin <= 1'b0;
            r_state     <= WAIT_END;
          end else begin
            r_beg_cnt <= r_beg_cnt + 3'd1;
          end
        end
        WAIT_END: begin
          if (bus.alu_end) begin
            r_res_data    <= bus.alu_out;
            r_res_op      <= r_opnd.op;
            r_res_timeout <= 1'b0;
            r_res_valid   <= 1'b1;
            r_state       <= HOLD;
          end else if (w_wd_tc) begin
            r_res_data    <= '0;
            r_res_op      <= r_opnd.op;
            r_res_timeout <= 1'b1;
            r_res_valid   <= 1'b1;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Accept overrides the HOLD->IDLE fallback so back-to-back requests skip IDLE
      if (w_accept) begin
        r_opnd.x     <= bus.req_x;
        r_opnd.y     <= bus.req_y;
        r_opnd.a_div <= bus.req_a_div;
        r_opnd.op    <= bus.req_op;
        r_alu_begin  <= 1'b1;
        r_beg_cnt    <= '0;
        r_busy       <= 1'b1;
        r_state      <= LAUNCH;
      end
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.alu_x       = r_opnd.x;
  assign bus.alu_y       = r_opnd.y;
  assign bus.alu_a_div   = r_opnd.a_div;
  assign bus.alu_op      = r_opnd.op;
  assign bus.alu_begin   = r_alu_begin;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_data    = r_res_data;
  assign bus.res_op      = r_res_op;
  assign bus.res_timeout = r_res_timeout;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: the bench plays requester, ALU and consumer, and predicts each
// result, latency and BEGIN width from the transaction's chosen END delay.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int B  = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(
    .BEGIN_CYCLES (B),
    .TIMEOUT      (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Current transaction: operands, END delay in WAIT_END cycles (>TO means never), ALU result
  logic [7:0]  c_x, c_y, c_a;
  logic [2:0]  c_op;
  int          c_nend;
  logic [15:0] c_out;
  logic [15:0] e_data;
  logic        e_to;

  task automatic set_req(input logic [7:0] x, input logic [7:0] y, input logic [7:0] a,
                         input logic [2:0] op, input int nend, input logic [15:0] out);
    c_x = x; c_y = y; c_a = a; c_op = op; c_nend = nend; c_out = out;
    bus.req_x = x; bus.req_y = y; bus.req_a_div = a; bus.req_op = op;
    bus.req_valid = 1'b1;
  endtask

  task automatic rand_req();
    set_req(8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
            $urandom_range(1, TO + 3), 16'($urandom));
  endtask

  task automatic do_reset(input string tag);
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.alu_end   = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_alu_begin"}, bus.alu_begin, 0);
    check({tag, "_res_data"}, bus.res_data, 0);
    check({tag, "_res_timeout"}, bus.res_timeout, 0);
    check({tag, "_alu_x"}, bus.alu_x, 0);
  endtask

  // Called at a negedge with a request presented; steps to the first cycle showing res_valid.
  task automatic run_txn();
    int lat, beg, k, n_exp;
    bit done;
    lat = 0; beg = 0; k = 0; done = 0;
    e_to   = (c_nend > TO);
    e_data = e_to ? 16'h0000 : c_out;
    n_exp  = e_to ? TO : c_nend;
    #1;
    check("req_ready_at_accept", bus.req_ready, 1);
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.req_x = 8'($urandom); bus.req_y = 8'($urandom);
        bus.req_a_div = 8'($urandom); bus.req_op = 3'($urandom);
        check("launch_next_cycle", bus.alu_begin, 1);
        check("res_valid_dropped", bus.res_valid, 0);
        check("busy_launch", bus.busy, 1);
      end
      if (bus.res_valid) begin
        done = 1;
        bus.alu_end = 1'($urandom);
      end else if (bus.alu_begin) begin
        beg++;
        bus.alu_end = 1'($urandom);
        bus.alu_out = 16'($urandom);
      end else begin
        k++;
        bus.alu_end = (k == c_nend);
        bus.alu_out = (k == c_nend) ? c_out : 16'($urandom);
      end
    end
    check("res_valid_seen", 32'(done), 1);
    check("latency", lat, B + n_exp + 1);
    check("begin_width", beg, B);
    check("res_data", bus.res_data, e_data);
    check("res_op", bus.res_op, c_op);
    check("res_timeout", bus.res_timeout, e_to);
    check("operands", {bus.alu_a_div, bus.alu_x, bus.alu_y, bus.alu_op}, {c_a, c_x, c_y, c_op});
  endtask

  // Holds the result for nhold cycles, then releases; with b2b a new request rides the release.
  task automatic hold_release(input int nhold, input bit b2b);
    for (int i = 0; i < nhold; i++) begin
      check("hold_valid", bus.res_valid, 1);
      check("hold_data", bus.res_data, e_data);
      check("hold_to", bus.res_timeout, e_to);
      check("hold_req_ready", bus.req_ready, 0);
      check("hold_begin", bus.alu_begin, 0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    if (b2b) begin
      rand_req();
    end else begin
      bus.req_valid = 1'b0;
      #1;
      check("release_req_ready", bus.req_ready, 1);
      @(negedge clk);
      check("idle_res_valid", bus.res_valid, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_req_ready", bus.req_ready, 1);
      bus.res_ready = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.req_a_div = '0; bus.req_op = '0;
    bus.alu_end = 1'b0; bus.alu_out = '0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset("por");

    // Reset in the middle of WAIT_END
    set_req(8'hAA, 8'h55, 8'h11, OP_OR, 100, 16'h1234);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (B + 3) @(negedge clk);
    check("busy_in_wait", bus.busy, 1);
    do_reset("rst_wait");

    set_req(8'hF0, 8'h3C, 8'h00, OP_AND, 3, 16'h0030);
    run_txn();
    hold_release(0, 0);

    set_req(8'h07, 8'h05, 8'h00, 3'b100, 3, 16'h0023);
    run_txn();
    hold_release(1, 0);

    // Watchdog expiry, then a normal completion
    set_req(8'h01, 8'h02, 8'h03, OP_XOR, TO + 5, 16'hDEAD);
    run_txn();
    hold_release(2, 0);
    set_req(8'h10, 8'h20, 8'h30, OP_OR, 2, 16'h00C5);
    run_txn();

    // Backpressure for 10 cycles, then release straight into the next launch
    hold_release(10, 1);
    run_txn();
    hold_release(0, 0);

    // END exactly on the terminal watchdog cycle
    set_req(8'h33, 8'h44, 8'h55, OP_AND, TO, 16'hBEEF);
    run_txn();
    hold_release(0, 0);

    // Reset while holding a valid result
    set_req(8'h66, 8'h77, 8'h88, OP_XOR, 1, 16'h4242);
    run_txn();
    do_reset("rst_hold");

    rand_req();
    for (int t = 0; t < 40; t++) begin
      bit b2b;
      b2b = 1'($urandom);
      run_txn();
      hold_release($urandom_range(0, 3), b2b);
      if (!b2b) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rand_req();
      end
    end
    run_txn();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
